// File: rtl/adc_sequencer_if.sv
// Wishbone slave bus bundle for adc_sequencer.
// master drives strobe/cycle/write/address/data; slave returns data/ack.
interface adc_sequencer_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/adc_sequencer.sv
// ADC channel sweeper: settle, average 2^AVG_LOG2 conversions, strobe out.
// Ports: wb_clk_i/wb_rst_i, wb (regs), adc_* macro side, adc_strb/channel/result out.
module adc_sequencer #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  adc_sequencer_if.slave wb,
  output logic        adc_start_o,
  output logic [4:0]  adc_chnum_o,
  input  logic        adc_busy_i,
  input  logic        adc_datavalid_i,
  input  logic [11:0] adc_result_i,
  output logic        adc_strb,
  output logic [4:0]  adc_channel,
  output logic [11:0] adc_result
);

  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] NCONV = CW'(1 << AVG_LOG2);
  localparam logic [SW-1:0] SLOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_EMIT   = 3'd5;

  logic [31:0]   mask_q;
  logic          run_q;
  logic          tout_q;
  logic [2:0]    state_q;
  logic [SW-1:0] settle_q;
  logic [TW-1:0] tmo_q;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;

  logic          wb_req;
  logic          go;
  logic          tmo_evt;
  logic          tout_clr;
  logic [AW-1:0] acc_sum;
  logic [CW-1:0] cnt_inc;
  logic [4:0]    nxt_lo;
  logic [4:0]    nxt_hi;
  logic          hi_ok;
  logic [4:0]    nxt_ch;

  assign wb_req  = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign go      = run_q & (|mask_q);
  assign acc_sum = acc_q + AW'(adc_result_i);
  assign cnt_inc = cnt_q + 1'b1;
  assign tmo_evt = (state_q == ST_WAIT) & ~adc_datavalid_i
                 & (tmo_q == '0);
  assign tout_clr = wb_req & wb.wb_we_i
                  & (wb.wb_adr_i[1:0] == 2'd3) & wb.wb_dat_i[1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb.wb_ack_o <= 1'b0;
      mask_q      <= 32'hFFFF_FFFF;
      run_q       <= 1'b1;
    end else begin
      wb.wb_ack_o <= wb_req;
      if (wb_req && wb.wb_we_i) begin
        case (wb.wb_adr_i[1:0])
          2'd0:    mask_q[15:0]  <= wb.wb_dat_i;
          2'd1:    mask_q[31:16] <= wb.wb_dat_i;
          2'd2:    run_q         <= wb.wb_dat_i[0];
          default: ;
        endcase
      end
    end
  end

  // A timeout in the same cycle as a clear request stays set.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) tout_q <= 1'b0;
    else if (tmo_evt) tout_q <= 1'b1;
    else if (tout_clr) tout_q <= 1'b0;
  end

  always_comb begin
    wb.wb_dat_o = '0;
    case (wb.wb_adr_i[1:0])
      2'd0: wb.wb_dat_o = mask_q[15:0];
      2'd1: wb.wb_dat_o = mask_q[31:16];
      2'd2: wb.wb_dat_o = {15'd0, run_q};
      2'd3: wb.wb_dat_o = {1'b0, state_q, 3'd0, adc_chnum_o,
                           2'd0, tout_q, run_q};
      default: ;
    endcase
  end

  // Scanning downward leaves the lowest hit in each candidate.
  always_comb begin
    nxt_lo = '0;
    nxt_hi = '0;
    hi_ok  = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (mask_q[i]) begin
        nxt_lo = 5'(i);
        if (5'(i) > adc_chnum_o) begin
          nxt_hi = 5'(i);
          hi_ok  = 1'b1;
        end
      end
    end
  end

  assign nxt_ch = hi_ok ? nxt_hi : nxt_lo;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      adc_start_o <= 1'b0;
      adc_chnum_o <= 5'd31;
      adc_strb    <= 1'b0;
      adc_channel <= '0;
      adc_result  <= '0;
      settle_q    <= '0;
      tmo_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      adc_start_o <= 1'b0;
      adc_strb    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) state_q <= ST_SELECT;
        end
        ST_SELECT: begin
          if (!go) begin
            state_q <= ST_IDLE;
          end else begin
            adc_chnum_o <= nxt_ch;
            acc_q       <= '0;
            cnt_q       <= '0;
            settle_q    <= SLOAD;
            state_q     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!go) state_q <= ST_IDLE;
          else if (settle_q == '0) state_q <= ST_START;
          else settle_q <= settle_q - 1'b1;
        end
        ST_START: begin
          if (!go) begin
            state_q <= ST_IDLE;
          end else if (!adc_busy_i) begin
            adc_start_o <= 1'b1;
            tmo_q       <= TLOAD;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Valid wins over a same-cycle timeout; RUN=0 drops the sample.
          if (adc_datavalid_i) begin
            if (!run_q) begin
              state_q <= ST_IDLE;
            end else if (cnt_inc == NCONV) begin
              adc_strb    <= 1'b1;
              adc_channel <= adc_chnum_o;
              adc_result  <= acc_sum[AW-1:AVG_LOG2];
              state_q     <= ST_EMIT;
            end else begin
              acc_q   <= acc_sum;
              cnt_q   <= cnt_inc;
              state_q <= ST_START;
            end
          end else if (tmo_q == '0) begin
            state_q <= run_q ? ST_SELECT : ST_IDLE;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        ST_EMIT: begin
          state_q <= run_q ? ST_SELECT : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with a behavioural ADC model.
// Model: latency 10, result = channel*100 (or 1000+k on ch6 in one test).
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start;
  logic        busy = 1'b0;
  logic        dv = 1'b0;
  logic [4:0]  chnum;
  logic [11:0] ares = '0;
  logic        strb;
  logic [4:0]  och;
  logic [11:0] ores;

  always #5 clk = ~clk;

  adc_sequencer_if wb();

  adc_sequencer dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wb              (wb),
    .adc_start_o     (start),
    .adc_chnum_o     (chnum),
    .adc_busy_i      (busy),
    .adc_datavalid_i (dv),
    .adc_result_i    (ares),
    .adc_strb        (strb),
    .adc_channel     (och),
    .adc_result      (ores)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int lat_cnt = 0;
  logic [11:0] pend = '0;
  int skip_ch = -1;
  bit ch6_mode = 1'b0;
  int k6 = 0;

  always @(negedge clk) begin
    dv = 1'b0;
    if (start) begin
      if (int'(chnum) != skip_ch) begin
        busy = 1'b1;
        lat_cnt = 10;
        if (ch6_mode && chnum == 5'd6) begin
          pend = 12'(1000 + k6);
          k6++;
        end else begin
          pend = 12'(int'(chnum) * 100);
        end
      end
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        dv = 1'b1;
        ares = pend;
        busy = 1'b0;
      end
    end
  end

  int q_ch[$];
  int q_res[$];
  int q_cyc[$];
  int cyc = 0;
  int n_start = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (strb) begin
        q_ch.push_back(int'(och));
        q_res.push_back(int'(ores));
        q_cyc.push_back(cyc);
      end
      if (start) n_start++;
    end
  end

  task automatic wb_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    wb.wb_adr_i = {14'd0, a};
    wb.wb_dat_i = d;
    wb.wb_we_i  = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check("wr_ack", {31'd0, wb.wb_ack_o}, 1);
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    wb.wb_adr_i = {14'd0, a};
    wb.wb_we_i  = 1'b0;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check("rd_ack", {31'd0, wb.wb_ack_o}, 1);
    d = wb.wb_dat_o;
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (q_ch.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("strobe_count", q_ch.size(), n);
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    while (start !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("start_seen", {31'd0, start}, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q_ch.delete();
    q_res.delete();
    q_cyc.delete();
    n_start = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outs();
    check("rst_start", {31'd0, start}, 0);
    check("rst_chnum", {27'd0, chnum}, 31);
    check("rst_strb", {31'd0, strb}, 0);
    check("rst_channel", {27'd0, och}, 0);
    check("rst_result", {20'd0, ores}, 0);
    check("rst_ack", {31'd0, wb.wb_ack_o}, 0);
  endtask

  logic [15:0] d;

  initial begin
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;

    // Reset defaults and full sweep
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs();
    rst = 1'b0;
    wb_read(2'd3, d);
    check("status_run_tout", {30'd0, d[1:0]}, 1);
    wb_read(2'd0, d);
    check("mask_lo_rst", {16'd0, d}, 32'hFFFF);
    wb_read(2'd2, d);
    check("ctrl_rst", {16'd0, d}, 1);
    wait_strobes(33, 2600);
    for (int i = 0; i < 33; i++)
      check($sformatf("sweep_ch%0d", i), q_ch[i], i % 32);
    check("ch5_result", q_res[5], 500);
    check("ch31_result", q_res[31], 3100);
    check("spacing", q_cyc[2] - q_cyc[1], 66);
    check("spacing_wrap", q_cyc[32] - q_cyc[31], 66);

    // Two-channel mask with averaging on ch6
    do_reset();
    ch6_mode = 1'b1;
    k6 = 0;
    wb_write(2'd0, 16'h0041);
    wb_write(2'd1, 16'h0000);
    wait_strobes(1, 200);
    wb_read(2'd3, d);
    check("status_chnum", {27'd0, d[8:4]}, 6);
    wait_strobes(4, 400);
    check("m_ch0", q_ch[0], 0);
    check("m_ch1", q_ch[1], 6);
    check("m_ch2", q_ch[2], 0);
    check("m_ch3", q_ch[3], 6);
    check("m_res0", q_res[0], 0);
    check("m_res6a", q_res[1], 1001);
    check("m_res6b", q_res[3], 1005);
    ch6_mode = 1'b0;

    // Timeout on ch3
    do_reset();
    skip_ch = 3;
    wait_strobes(4, 2000);
    check("to_ch0", q_ch[0], 0);
    check("to_ch1", q_ch[1], 1);
    check("to_ch2", q_ch[2], 2);
    check("to_next", q_ch[3], 4);
    check("to_gap", q_cyc[3] - q_cyc[2], 66 + 1 + 16 + 1 + 1024);
    wb_read(2'd3, d);
    check("tout_set", {31'd0, d[1]}, 1);
    wb_write(2'd3, 16'h0002);
    wb_read(2'd3, d);
    check("tout_clr", {31'd0, d[1]}, 0);
    skip_ch = -1;

    // RUN cleared in WAIT
    do_reset();
    wait_strobes(1, 200);
    wait_start(200);
    wb_write(2'd2, 16'h0000);
    repeat (30) @(posedge clk);
    check("stop_no_strobe", q_ch.size(), 1);
    wb_read(2'd3, d);
    check("stop_state", {29'd0, d[14:12]}, 0);
    check("stop_run", {31'd0, d[0]}, 0);
    wb_write(2'd2, 16'h0001);
    wait_strobes(2, 200);
    check("resume_ch", q_ch[1], 2);

    // Mask cleared during SETTLE
    do_reset();
    wb_write(2'd0, 16'h0000);
    wb_write(2'd1, 16'h0000);
    repeat (40) @(posedge clk);
    check("mask0_starts", n_start, 0);
    check("mask0_strobes", q_ch.size(), 0);
    wb_read(2'd3, d);
    check("mask0_state", {29'd0, d[14:12]}, 0);
    wb_write(2'd0, 16'hFFFF);
    wait_strobes(1, 200);
    check("mask_restore_ch", q_ch[0], 1);

    // Reset during WAIT with a stale datavalid afterwards
    do_reset();
    wait_strobes(1, 200);
    wait_start(200);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q_ch.delete();
    q_res.delete();
    q_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    rst = 1'b0;
    repeat (14) @(posedge clk);
    check("stale_no_strobe", q_ch.size(), 0);
    check("stale_chnum", {27'd0, chnum}, 0);
    wait_strobes(1, 200);
    check("restart_ch", q_ch[0], 0);
    check("restart_res", q_res[0], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
